// File: rtl/mem_responder.sv
// mem_responder: single-port word memory answering the core's load/store bus.
// One request at a time via req/ready, WAIT_CYCLES wait states, one-cycle ack.
// After reset the whole array is swept to zero before any request is accepted.
// Build option: define MEM_PARITY_EN to store an even-parity bit per word and
// report mismatches on loads through perr (err_inject corrupts a store's parity).
module mem_responder #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic                 err_inject,
  output logic                 ready,
  output logic                 ack,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 perr,
  output logic [WORD_SIZE-1:0] last_wr,
  output logic                 busy_clear
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {StClear, StIdle, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  accept;

  // Request latched at accept
  logic                  wr_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [WORD_SIZE-1:0]  wdata_q;

  logic                  ack_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic [WORD_SIZE-1:0]  last_wr_q;

  // Single write port shared by the clear sweep and store commits
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [WORD_SIZE-1:0]  mem_wdata;

  logic [WORD_SIZE-1:0]  mem [Depth];

`ifdef MEM_PARITY_EN
  logic                  inj_q;
  logic                  perr_q;
  logic                  mem_wpar;
  logic                  mem_par [Depth];
`else
  logic                  unused_inject;
  assign unused_inject = err_inject;
`endif

  // Next-state logic and write-port steering
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
`ifdef MEM_PARITY_EN
    mem_wpar  = 1'b0;
`endif
    unique case (state_q)
      StClear: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          cnt_d   = WaitInit;
          state_d = (WaitInit != 4'd0) ? StWait : StDone;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        // <= guards against a zero count ever stranding the FSM here
        if (cnt_q <= 4'd1) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (wr_q) begin
          mem_we    = 1'b1;
          mem_waddr = addr_q;
          mem_wdata = wdata_q;
`ifdef MEM_PARITY_EN
          mem_wpar  = (^wdata_q) ^ inj_q;
`endif
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Control state, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StClear;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      last_wr_q <= '0;
`ifdef MEM_PARITY_EN
      inj_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_q == StDone);
      if (accept) begin
        wr_q    <= write;
        addr_q  <= addr;
        wdata_q <= wdata;
`ifdef MEM_PARITY_EN
        inj_q   <= err_inject;
`endif
      end
      if (state_q == StDone) begin
        if (wr_q) begin
          last_wr_q <= wdata_q;
`ifdef MEM_PARITY_EN
          perr_q    <= 1'b0;
`endif
        end else begin
          rdata_q <= mem[addr_q];
`ifdef MEM_PARITY_EN
          perr_q  <= (^mem[addr_q]) ^ mem_par[addr_q];
`endif
        end
      end
    end
  end

  // Array write; gated by rst_n so a store caught by reset never commits
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef MEM_PARITY_EN
      mem_par[mem_waddr] <= mem_wpar;
`endif
    end
  end

  assign ready      = (state_q == StIdle);
  assign busy_clear = (state_q == StClear);
  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign last_wr    = last_wr_q;
`ifdef MEM_PARITY_EN
  assign perr       = perr_q;
`else
  assign perr       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES=0 and 1) sharing the
// request fields, each with its own req. Stimulus pushes expected responses;
// a negedge monitor pops them on every ack and checks data and ack cycle.
module tb_mem_responder;

`ifdef MEM_PARITY_EN
  localparam bit ParityBuild = 1'b1;
`else
  localparam bit ParityBuild = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        write;
  logic        err_inject;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  req;
  logic [1:0]  ready;
  logic [1:0]  ack;
  logic [1:0]  perr;
  logic [1:0]  busy;
  logic [15:0] rdata [2];
  logic [15:0] last_wr [2];

  mem_responder #(.WORD_SIZE(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .write(write), .addr(addr),
    .wdata(wdata), .err_inject(err_inject), .ready(ready[0]), .ack(ack[0]),
    .rdata(rdata[0]), .perr(perr[0]), .last_wr(last_wr[0]), .busy_clear(busy[0])
  );

  mem_responder #(.WORD_SIZE(16), .ADDR_W(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .write(write), .addr(addr),
    .wdata(wdata), .err_inject(err_inject), .ready(ready[1]), .ack(ack[1]),
    .rdata(rdata[1]), .perr(perr[1]), .last_wr(last_wr[1]), .busy_clear(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          is_load;
    logic [15:0] rdata;
    logic        perr;
    logic [15:0] last_wr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_ack(input int i, input exp_t e);
    check($sformatf("dut%0d ack cycle", i), e.cyc - 0, cyc);
    if (e.is_load) begin
      check($sformatf("dut%0d rdata", i), rdata[i], e.rdata);
      check($sformatf("dut%0d perr", i), perr[i], e.perr);
    end
    check($sformatf("dut%0d last_wr", i), last_wr[i], e.last_wr);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (ack[0]) begin
      n_tests++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL dut0 unexpected ack at cycle %0d, want no ack", cyc);
      end else begin
        e = q0.pop_front();
        check_ack(0, e);
      end
    end
    if (ack[1]) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL dut1 unexpected ack at cycle %0d, want no ack", cyc);
      end else begin
        e = q1.pop_front();
        check_ack(1, e);
      end
    end
  end

  task automatic wait_ready(input int i);
    int unsigned waited = 0;
    while (!ready[i] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!ready[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL dut%0d ready timeout: got ready=0, want 1 within 100 cycles", i);
    end
  endtask

  // One handshake; ack is expected 1+WAIT_CYCLES edges after the accept edge
  task automatic issue(input int i, input bit wr, input logic [7:0] a, input logic [15:0] d,
                       input bit inj, input logic [15:0] exp_rd, input bit exp_perr,
                       input logic [15:0] exp_lw);
    exp_t e;
    wait_ready(i);
    if (!ready[i]) return;
    write      = wr;
    addr       = a;
    wdata      = d;
    err_inject = inj;
    req[i]     = 1'b1;
    @(posedge clk);
    #1;
    req[i]     = 1'b0;
    err_inject = 1'b0;
    e.cyc      = cyc + 1 + ((i == 0) ? 0 : 1);
    e.is_load  = !wr;
    e.rdata    = exp_rd;
    e.perr     = exp_perr;
    e.last_wr  = exp_lw;
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Release reset at a negedge and measure how long the clear sweep keeps ready low
  task automatic release_and_check_clear();
    int unsigned n = 0;
    rst_n = 1'b1;
    while (busy[1] && !ready[1] && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("clear duration", n, 256);
    check("dut1 ready after clear", ready[1], 1'b1);
    check("dut1 busy_clear after clear", busy[1], 1'b0);
    check("dut0 ready after clear", ready[0], 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int unsigned e0;
    rst_n      = 1'b0;
    req        = 2'b00;
    write      = 1'b0;
    addr       = '0;
    wdata      = '0;
    err_inject = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("reset ready", ready, 2'b00);
    check("reset busy_clear", busy, 2'b11);
    check("reset ack", ack, 2'b00);
    check("reset perr", perr, 2'b00);
    check("reset rdata", rdata[1], 16'h0000);
    check("reset last_wr", last_wr[1], 16'h0000);

    release_and_check_clear();

    // Cleared array reads zero at the top address
    issue(1, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    issue(0, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);

    // Store then load, same address
    issue(1, 1'b1, 8'h3C, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'hBEEF);
    issue(1, 1'b0, 8'h3C, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF);
    issue(1, 1'b1, 8'h00, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 16'h5A5A);
    issue(1, 1'b0, 8'h00, 16'h0000, 1'b0, 16'h5A5A, 1'b0, 16'h5A5A);
    issue(1, 1'b0, 8'h3C, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 16'h5A5A);

    // Parity fault injection
    issue(1, 1'b1, 8'h10, 16'h1234, 1'b1, 16'h0000, 1'b0, 16'h1234);
    issue(1, 1'b0, 8'h10, 16'h0000, 1'b0, 16'h1234, ParityBuild, 16'h1234);

    // Zero-wait instance
    issue(0, 1'b1, 8'hFF, 16'hC3C3, 1'b0, 16'h0000, 1'b0, 16'hC3C3);
    issue(0, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'hC3C3, 1'b0, 16'hC3C3);

    // Held req on the zero-wait instance: accepts at E0, E0+2, E0+4, E0+6
    @(negedge clk);
    wait_ready(0);
    write  = 1'b0;
    addr   = 8'hFF;
    req[0] = 1'b1;
    e0     = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      e.cyc     = e0 + 1 + 2 * k;
      e.is_load = 1'b1;
      e.rdata   = 16'hC3C3;
      e.perr    = 1'b0;
      e.last_wr = 16'hC3C3;
      q0.push_back(e);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("held req ready k=%0d", k), ready[0], (k % 2 == 1) ? 1'b1 : 1'b0);
    end
    req[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("dut0 queue drained", q0.size(), 0);

    // Store accepted, then reset during WAIT: no ack, no commit, sweep reruns
    wait_ready(1);
    write  = 1'b1;
    addr   = 8'h05;
    wdata  = 16'hAAAA;
    req[1] = 1'b1;
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset-abort busy_clear", busy[1], 1'b1);
    check("reset-abort last_wr", last_wr[1], 16'h0000);
    release_and_check_clear();

    issue(1, 1'b0, 8'h05, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
    issue(1, 1'b0, 8'h3C, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);

    repeat (6) @(negedge clk);
    check("dut0 pending acks", q0.size(), 0);
    check("dut1 pending acks", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
